// File: rtl/grid_ctl.sv
// grid_ctl: sequencing controller for the 12x12 two-bit grid status memory.
// Owns the memory's single read/write port. It sweeps the grid to EMPTY after
// reset or on request, and serves shot and place requests as 4-cycle
// read-modify-write sequences. It also tracks the number of unhit ship cells.
// All outputs are registered from next-state values, so they line up with the
// state they belong to (RD drives the read address, WR drives the write and ack).
module grid_ctl #(
  parameter int unsigned GRID_ROWS    = 12,
  parameter int unsigned GRID_COLUMNS = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear_req,
  input  logic       shot_req,
  input  logic [7:0] shot_addr,
  output logic       shot_ack,
  output logic [1:0] shot_result,
  output logic       shot_repeat,
  input  logic       place_req,
  input  logic [7:0] place_addr,
  output logic       place_ack,
  output logic       place_ok,
  output logic [7:0] mem_addr,
  output logic       mem_we,
  output logic [1:0] mem_wdata,
  input  logic [1:0] mem_rdata,
  output logic [7:0] ships_left,
  output logic       fleet_sunk,
  output logic       busy
);

  localparam logic [1:0] CELL_EMPTY  = 2'b00;
  localparam logic [1:0] CELL_MYSHIP = 2'b01;
  localparam logic [1:0] CELL_MISS   = 2'b10;
  localparam logic [1:0] CELL_HIT    = 2'b11;

  localparam logic [4:0] ROW_LIM   = 5'(GRID_ROWS);
  localparam logic [4:0] COL_LIM   = 5'(GRID_COLUMNS);
  localparam logic [7:0] MAX_SHIPS = 8'(GRID_ROWS * GRID_COLUMNS);
  localparam logic [7:0] LAST_ADDR = 8'hFF;

  typedef enum logic [2:0] {
    CLEAR = 3'd0,
    IDLE  = 3'd1,
    RD    = 3'd2,
    EVAL  = 3'd3,
    WR    = 3'd4
  } state_t;

  state_t     state, state_n;
  logic [7:0] clr_cnt, clr_cnt_n;
  logic       op_shot, op_shot_n;
  logic [7:0] op_addr, op_addr_n;

  logic       shot_ack_n, shot_repeat_n, place_ack_n, place_ok_n;
  logic [1:0] shot_result_n, mem_wdata_n;
  logic [7:0] mem_addr_n, ships_left_n;
  logic       mem_we_n, fleet_sunk_n;
  logic       in_range;

  // Latched address lies inside the GRID_COLUMNS x GRID_ROWS grid
  always_comb begin
    in_range = ({1'b0, op_addr[7:4]} < COL_LIM) && ({1'b0, op_addr[3:0]} < ROW_LIM);
  end

  // Next-state and next-output logic
  always_comb begin
    state_n       = state;
    clr_cnt_n     = clr_cnt;
    op_shot_n     = op_shot;
    op_addr_n     = op_addr;
    mem_addr_n    = mem_addr;
    mem_we_n      = 1'b0;
    mem_wdata_n   = CELL_EMPTY;
    shot_ack_n    = 1'b0;
    shot_result_n = shot_result;
    shot_repeat_n = shot_repeat;
    place_ack_n   = 1'b0;
    place_ok_n    = place_ok;
    ships_left_n  = ships_left;
    fleet_sunk_n  = 1'b0;

    unique case (state)
      CLEAR: begin
        ships_left_n = 8'd0;
        // clr_cnt is the next address to write; stop once 0xFF has been written
        if (mem_we && (mem_addr == LAST_ADDR)) begin
          state_n = IDLE;
        end else begin
          mem_addr_n = clr_cnt;
          mem_we_n   = 1'b1;
          clr_cnt_n  = clr_cnt + 8'd1;
        end
      end

      IDLE: begin
        if (clear_req) begin
          state_n      = CLEAR;
          mem_addr_n   = 8'd0;
          mem_we_n     = 1'b1;
          clr_cnt_n    = 8'd1;
          ships_left_n = 8'd0;
        end else if (shot_req) begin
          state_n    = RD;
          op_shot_n  = 1'b1;
          op_addr_n  = shot_addr;
          mem_addr_n = shot_addr;
        end else if (place_req) begin
          state_n    = RD;
          op_shot_n  = 1'b0;
          op_addr_n  = place_addr;
          mem_addr_n = place_addr;
        end
      end

      RD: begin
        state_n = EVAL;
      end

      EVAL: begin
        state_n = WR;
        if (op_shot) begin
          shot_ack_n = 1'b1;
          if (!in_range) begin
            shot_result_n = CELL_MISS;
            shot_repeat_n = 1'b1;
          end else begin
            unique case (mem_rdata)
              CELL_EMPTY: begin
                mem_we_n      = 1'b1;
                mem_wdata_n   = CELL_MISS;
                shot_result_n = CELL_MISS;
                shot_repeat_n = 1'b0;
              end
              CELL_MYSHIP: begin
                mem_we_n      = 1'b1;
                mem_wdata_n   = CELL_HIT;
                shot_result_n = CELL_HIT;
                shot_repeat_n = 1'b0;
                if (ships_left != 8'd0) begin
                  ships_left_n = ships_left - 8'd1;
                end
                fleet_sunk_n = (ships_left == 8'd1);
              end
              default: begin
                shot_result_n = mem_rdata;
                shot_repeat_n = 1'b1;
              end
            endcase
          end
        end else begin
          place_ack_n = 1'b1;
          if (in_range && (mem_rdata == CELL_EMPTY)) begin
            mem_we_n    = 1'b1;
            mem_wdata_n = CELL_MYSHIP;
            place_ok_n  = 1'b1;
            if (ships_left < MAX_SHIPS) begin
              ships_left_n = ships_left + 8'd1;
            end
          end else begin
            place_ok_n = 1'b0;
          end
        end
      end

      WR: begin
        state_n = IDLE;
      end

      default: begin
        state_n = CLEAR;
      end
    endcase
  end

  // State, latched request and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= CLEAR;
      clr_cnt     <= 8'd0;
      op_shot     <= 1'b0;
      op_addr     <= 8'd0;
      mem_addr    <= 8'd0;
      mem_we      <= 1'b0;
      mem_wdata   <= 2'b00;
      shot_ack    <= 1'b0;
      shot_result <= 2'b00;
      shot_repeat <= 1'b0;
      place_ack   <= 1'b0;
      place_ok    <= 1'b0;
      ships_left  <= 8'd0;
      fleet_sunk  <= 1'b0;
      busy        <= 1'b1;
    end else begin
      state       <= state_n;
      clr_cnt     <= clr_cnt_n;
      op_shot     <= op_shot_n;
      op_addr     <= op_addr_n;
      mem_addr    <= mem_addr_n;
      mem_we      <= mem_we_n;
      mem_wdata   <= mem_wdata_n;
      shot_ack    <= shot_ack_n;
      shot_result <= shot_result_n;
      shot_repeat <= shot_repeat_n;
      place_ack   <= place_ack_n;
      place_ok    <= place_ok_n;
      ships_left  <= ships_left_n;
      fleet_sunk  <= fleet_sunk_n;
      busy        <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_grid_ctl.sv
// Self-checking bench for grid_ctl with a 1-cycle-latency RAM model.
module tb_grid_ctl;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear_req, shot_req, place_req;
  logic [7:0] shot_addr, place_addr;
  logic       shot_ack, shot_repeat, place_ack, place_ok;
  logic [1:0] shot_result;
  logic [7:0] mem_addr;
  logic       mem_we;
  logic [1:0] mem_wdata;
  logic [1:0] mem_rdata;
  logic [7:0] ships_left;
  logic       fleet_sunk, busy;

  int checks = 0;
  int errors = 0;

  logic [1:0] ram [0:255];

  grid_ctl #(.GRID_ROWS(12), .GRID_COLUMNS(12)) dut (
    .clk(clk), .rst(rst), .clear_req(clear_req),
    .shot_req(shot_req), .shot_addr(shot_addr), .shot_ack(shot_ack),
    .shot_result(shot_result), .shot_repeat(shot_repeat),
    .place_req(place_req), .place_addr(place_addr), .place_ack(place_ack),
    .place_ok(place_ok), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .ships_left(ships_left),
    .fleet_sunk(fleet_sunk), .busy(busy)
  );

  always #5 clk = ~clk;

  // Synchronous single-port grid memory
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       is_place;
    logic [7:0] addr;
    logic [1:0] res;
    logic       rep;
    logic       ok;
    logic       we;
    logic [1:0] wd;
    logic [7:0] ships;
    logic       sunk;
  } vec_t;

  vec_t vecs [13];

  initial begin
    int bad;
    int cnt;
    int shot_at, place_at, nwr;
    logic [7:0] wr_addr [4];
    logic       saw_ack;

    //           place addr   res    rep   ok    we    wd     ships  sunk
    vecs[0]  = '{1'b1, 8'h23, 2'b00, 1'b0, 1'b1, 1'b1, 2'b01, 8'd1, 1'b0};
    vecs[1]  = '{1'b1, 8'h23, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 8'd1, 1'b0};
    vecs[2]  = '{1'b0, 8'h23, 2'b11, 1'b0, 1'b0, 1'b1, 2'b11, 8'd0, 1'b1};
    vecs[3]  = '{1'b0, 8'h00, 2'b10, 1'b0, 1'b0, 1'b1, 2'b10, 8'd0, 1'b0};
    vecs[4]  = '{1'b0, 8'h00, 2'b10, 1'b1, 1'b0, 1'b0, 2'b00, 8'd0, 1'b0};
    vecs[5]  = '{1'b0, 8'hC0, 2'b10, 1'b1, 1'b0, 1'b0, 2'b00, 8'd0, 1'b0};
    vecs[6]  = '{1'b1, 8'h0C, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0, 1'b0};
    vecs[7]  = '{1'b1, 8'h55, 2'b00, 1'b0, 1'b1, 1'b1, 2'b01, 8'd1, 1'b0};
    vecs[8]  = '{1'b0, 8'h23, 2'b11, 1'b1, 1'b0, 1'b0, 2'b00, 8'd1, 1'b0};
    vecs[9]  = '{1'b1, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 8'd1, 1'b0};
    vecs[10] = '{1'b1, 8'hBB, 2'b00, 1'b0, 1'b1, 1'b1, 2'b01, 8'd2, 1'b0};
    vecs[11] = '{1'b0, 8'h55, 2'b11, 1'b0, 1'b0, 1'b1, 2'b11, 8'd1, 1'b0};
    vecs[12] = '{1'b0, 8'hFF, 2'b10, 1'b1, 1'b0, 1'b0, 2'b00, 8'd1, 1'b0};

    rst = 1'b1; clear_req = 1'b0; shot_req = 1'b0; place_req = 1'b0;
    shot_addr = 8'h00; place_addr = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_acks", 32'({shot_ack, place_ack, fleet_sunk}), 32'd0);
    chk("rst_ships", 32'(ships_left), 32'd0);
    rst = 1'b0;

    // Automatic sweep: 256 write cycles, addresses in order
    bad = 0;
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      if (!(busy && mem_we && mem_addr == 8'(k) && mem_wdata == 2'b00)) bad++;
    end
    chk("sweep_cycles_bad", 32'(bad), 32'd0);
    @(negedge clk);
    chk("sweep_done_busy", 32'(busy), 32'd0);
    chk("sweep_done_we", 32'(mem_we), 32'd0);
    chk("sweep_done_ships", 32'(ships_left), 32'd0);

    // Table-driven single requests, one every 4 cycles
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].is_place) begin place_req = 1'b1; place_addr = vecs[i].addr; end
      else begin shot_req = 1'b1; shot_addr = vecs[i].addr; end
      @(negedge clk);  // RD
      shot_req = 1'b0; place_req = 1'b0;
      shot_addr = 8'hEE; place_addr = 8'hEE;
      chk($sformatf("v%0d_rd_addr", i), 32'(mem_addr), 32'(vecs[i].addr));
      chk($sformatf("v%0d_rd_we", i), 32'(mem_we), 32'd0);
      @(negedge clk);  // EVAL
      chk($sformatf("v%0d_eval_acks", i), 32'({shot_ack, place_ack}), 32'd0);
      @(negedge clk);  // WR
      chk($sformatf("v%0d_acks", i), 32'({shot_ack, place_ack}),
          vecs[i].is_place ? 32'd1 : 32'd2);
      if (vecs[i].is_place) chk($sformatf("v%0d_ok", i), 32'(place_ok), 32'(vecs[i].ok));
      else chk($sformatf("v%0d_res_rep", i), 32'({shot_result, shot_repeat}),
               32'({vecs[i].res, vecs[i].rep}));
      chk($sformatf("v%0d_we", i), 32'(mem_we), 32'(vecs[i].we));
      if (vecs[i].we) chk($sformatf("v%0d_wr", i), 32'({mem_addr, mem_wdata}),
                          32'({vecs[i].addr, vecs[i].wd}));
      chk($sformatf("v%0d_ships", i), 32'(ships_left), 32'(vecs[i].ships));
      chk($sformatf("v%0d_sunk", i), 32'(fleet_sunk), 32'(vecs[i].sunk));
      @(negedge clk);  // IDLE
      chk($sformatf("v%0d_idle", i), 32'({busy, shot_ack, place_ack, fleet_sunk}), 32'd0);
    end
    chk("result_hold", 32'({shot_result, shot_repeat}), 32'({2'b10, 1'b1}));

    // Simultaneous shot (0x11) and place (0x22): shot first, place 4 cycles later
    shot_req = 1'b1; shot_addr = 8'h11; place_req = 1'b1; place_addr = 8'h22;
    shot_at = 0; place_at = 0; nwr = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (shot_ack) begin shot_at = c; shot_req = 1'b0; end
      if (place_ack) begin place_at = c; place_req = 1'b0; end
      if (mem_we) begin
        if (nwr < 4) wr_addr[nwr] = mem_addr;
        nwr++;
      end
    end
    shot_req = 1'b0; place_req = 1'b0;
    chk("sim_shot_ack_cycle", 32'(shot_at), 32'd3);
    chk("sim_place_ack_cycle", 32'(place_at), 32'd7);
    chk("sim_write_count", 32'(nwr), 32'd2);
    chk("sim_write_order", 32'({wr_addr[0], wr_addr[1]}), 32'({8'h11, 8'h22}));
    chk("sim_ships", 32'(ships_left), 32'd2);
    chk("sim_idle", 32'(busy), 32'd0);

    // clear_req raised during a place's EVAL cycle
    place_req = 1'b1; place_addr = 8'h33;
    @(negedge clk);  // RD
    place_req = 1'b0;
    @(negedge clk);  // EVAL
    clear_req = 1'b1;
    @(negedge clk);  // WR
    chk("clr_mid_place_ack", 32'({place_ack, place_ok}), 32'd3);
    chk("clr_mid_ships", 32'(ships_left), 32'd3);
    @(negedge clk);  // IDLE
    chk("clr_mid_idle", 32'({busy, mem_we}), 32'd0);
    @(negedge clk);  // first clear write
    clear_req = 1'b0;
    chk("clr_first_write", 32'({busy, mem_we, mem_addr}), 32'({1'b1, 1'b1, 8'h00}));
    chk("clr_ships_zero", 32'(ships_left), 32'd0);
    cnt = 1;
    while (busy && cnt < 300) begin
      @(negedge clk);
      if (busy) cnt++;
    end
    chk("clr_busy_cycles", 32'(cnt), 32'd256);
    bad = 0;
    for (int a = 0; a < 256; a++) if (ram[a] != 2'b00) bad++;
    chk("clr_grid_empty", 32'(bad), 32'd0);

    // Reset pulsed during RD: no ack, sweep restarts at address 0
    shot_req = 1'b1; shot_addr = 8'h44;
    @(negedge clk);  // RD
    shot_req = 1'b0;
    chk("rst_rd_addr", 32'(mem_addr), 32'h44);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_state", 32'({busy, mem_we, shot_ack}), 32'({1'b1, 1'b0, 1'b0}));
    @(negedge clk);
    chk("rst_mid_first", 32'({mem_we, mem_addr}), 32'({1'b1, 8'h00}));
    @(negedge clk);
    chk("rst_mid_second", 32'({mem_we, mem_addr}), 32'({1'b1, 8'h01}));
    saw_ack = 1'b0;
    cnt = 0;
    while (busy && cnt < 300) begin
      @(negedge clk);
      if (shot_ack || place_ack) saw_ack = 1'b1;
      cnt++;
    end
    chk("rst_mid_no_ack", 32'(saw_ack), 32'd0);
    chk("rst_mid_done", 32'(busy), 32'd0);
    chk("rst_mid_ships", 32'(ships_left), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
